// File: rtl/adc78h90_scanner.sv
// adc78h90_scanner
//   SPI master for the ADC78H90 housekeeping ADC. It scans channels
//   0..NCH-1 in a round-robin and presents one 12-bit conversion per frame,
//   marked by a single-cycle valid strobe.
//
//   Frame: SETUP (CS low, SCLK high) -> 16 SCLK periods -> HOLD -> GAP.
//   The address sent in a frame selects the conversion that is returned in
//   the next frame. For that reason the first frame after leaving IDLE is
//   discarded.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   scan_en      run continuous scan (sampled in IDLE and on the last GAP cycle)
//   ADCCLK       SPI SCLK, idles high
//   nADCCS       SPI chip select, active low
//   ADCMOSI      control word to the ADC, MSB first
//   ADCMISO      conversion data from the ADC
//   result       last conversion, unsigned straight binary
//   result_chan  channel that result belongs to
//   result_valid 1-clk strobe when result/result_chan update
//   busy         high while CS is low or the inter-frame gap is counting
module adc78h90_scanner #(
   parameter int CLK_DIV = 5,
   parameter int NCH     = 4,
   parameter int GAP     = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_en,
   output logic        ADCCLK,
   output logic        nADCCS,
   output logic        ADCMOSI,
   input  logic        ADCMISO,
   output logic [11:0] result,
   output logic [2:0]  result_chan,
   output logic        result_valid,
   output logic        busy
);

   localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [GW-1:0]   GAP_LAST = GW'(GAP - 1);
   localparam logic [2:0]      CH_LAST  = 3'(NCH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   function automatic logic [15:0] ctrl_word(input logic [2:0] addr);
      return {2'b00, addr, 11'b0};
   endfunction

   function automatic logic [2:0] next_chan(input logic [2:0] c);
      return (c == CH_LAST) ? 3'd0 : c + 3'd1;
   endfunction

   state_t          state_q;
   logic [7:0]      div_q;        // clk count inside the current half-period
   logic [3:0]      bit_q;        // SCLK period index n within SHIFT
   logic            hi_q;         // 0 = low half of SCLK period, 1 = high half
   logic [GW-1:0]   gap_q;
   logic [2:0]      chan_q;       // address sent in the current/next frame
   logic [2:0]      prev_chan_q;  // address sent in the previous frame
   logic            first_q;      // current frame returns stale data
   logic [15:0]     word_q;
   logic [11:0]     sr_q;         // only the last 12 bits received matter
   logic            miso_q;
   logic            sclk_q;
   logic            ncs_q;
   logic            mosi_q;
   logic [11:0]     result_q;
   logic [2:0]      rchan_q;
   logic            rvalid_q;
   logic            busy_q;
   logic [15:0]     start_word;

   assign start_word = ctrl_word(chan_q);

   always_ff @(posedge clk) begin
      miso_q <= ADCMISO;
      if (rst) begin
         state_q     <= S_IDLE;
         div_q       <= 8'd0;
         bit_q       <= 4'd0;
         hi_q        <= 1'b0;
         gap_q       <= '0;
         chan_q      <= 3'd0;
         prev_chan_q <= 3'd0;
         first_q     <= 1'b1;
         sclk_q      <= 1'b1;
         ncs_q       <= 1'b1;
         mosi_q      <= 1'b0;
         result_q    <= 12'd0;
         rchan_q     <= 3'd0;
         rvalid_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (scan_en) begin
                  state_q <= S_SETUP;
                  ncs_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  word_q  <= start_word;
                  mosi_q  <= start_word[15];
                  div_q   <= 8'd0;
               end
            end

            S_SETUP: begin
               if (div_q == DIV_LAST) begin
                  state_q <= S_SHIFT;
                  sclk_q  <= 1'b0;
                  mosi_q  <= word_q[15];
                  bit_q   <= 4'd0;
                  hi_q    <= 1'b0;
                  div_q   <= 8'd0;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end

            S_SHIFT: begin
               if (!hi_q) begin
                  if (div_q == DIV_LAST) begin
                     // Rising SCLK edge: capture the bit the ADC put out on the last fall.
                     sclk_q <= 1'b1;
                     sr_q   <= {sr_q[10:0], miso_q};
                     hi_q   <= 1'b1;
                     div_q  <= 8'd0;
                  end else begin
                     div_q <= div_q + 8'd1;
                  end
               end else begin
                  // First clk after the 16th rising edge: the word is complete.
                  if (div_q == 8'd0 && bit_q == 4'd15 && !first_q) begin
                     rvalid_q <= 1'b1;
                     result_q <= sr_q;
                     rchan_q  <= prev_chan_q;
                  end
                  if (div_q == DIV_LAST) begin
                     div_q <= 8'd0;
                     if (bit_q == 4'd15) begin
                        state_q <= S_HOLD;
                     end else begin
                        bit_q  <= bit_q + 4'd1;
                        sclk_q <= 1'b0;
                        hi_q   <= 1'b0;
                        mosi_q <= word_q[4'd14 - bit_q];
                     end
                  end else begin
                     div_q <= div_q + 8'd1;
                  end
               end
            end

            S_HOLD: begin
               if (div_q == DIV_LAST) begin
                  state_q     <= S_GAP;
                  ncs_q       <= 1'b1;
                  gap_q       <= '0;
                  div_q       <= 8'd0;
                  prev_chan_q <= chan_q;
                  chan_q      <= next_chan(chan_q);
                  first_q     <= 1'b0;
               end else begin
                  div_q <= div_q + 8'd1;
               end
            end

            S_GAP: begin
               if (gap_q == GAP_LAST) begin
                  if (scan_en) begin
                     state_q <= S_SETUP;
                     ncs_q   <= 1'b0;
                     word_q  <= start_word;
                     mosi_q  <= start_word[15];
                     div_q   <= 8'd0;
                  end else begin
                     // Leaving the scan: the next start must begin a fresh pipeline.
                     state_q <= S_IDLE;
                     busy_q  <= 1'b0;
                     chan_q  <= 3'd0;
                     first_q <= 1'b1;
                  end
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ADCCLK       = sclk_q;
   assign nADCCS       = ncs_q;
   assign ADCMOSI      = mosi_q;
   assign result       = result_q;
   assign result_chan  = rchan_q;
   assign result_valid = rvalid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_adc78h90_scanner.sv
`timescale 1ns/1ps
module tb_adc78h90_scanner;

   localparam int CLK_DIV = 5;
   localparam int NCH     = 4;
   localparam int GAP     = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scan_en = 1'b0;
   logic        ADCMISO = 1'b0;
   logic        ADCCLK, nADCCS, ADCMOSI, result_valid, busy;
   logic [11:0] result;
   logic [2:0]  result_chan;

   always #5 clk = ~clk;

   adc78h90_scanner #(.CLK_DIV(CLK_DIV), .NCH(NCH), .GAP(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .scan_en      (scan_en),
      .ADCCLK       (ADCCLK),
      .nADCCS       (nADCCS),
      .ADCMOSI      (ADCMOSI),
      .ADCMISO      (ADCMISO),
      .result       (result),
      .result_chan  (result_chan),
      .result_valid (result_valid),
      .busy         (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Stimulus-side controls (written only by the initial block)
   int phase       = 0;
   int restart_cnt = 0;
   int data_mode   = 0;   // 0: constant 12'hA5C, 1: 12'h100 + previous address
   int timeouts    = 0;

   // Monitor / ADC model state (written only by the monitor)
   logic [14:0] exp_q[$];
   int          seen_restart = 0;
   int          next_k = 0, cur_k = 0;
   int          nf = 0, nr = 0, lo_len = 0, hi_len = 0;
   int          cyc = 0, rise16_t = 0, viol = 0, busy_viol = 0;
   int          idle_act = 0, n_strobes = 0, p_phase = 0;
   logic        aborted = 1'b1, done = 1'b0;
   logic        p_cs = 1'b1, p_sclk = 1'b1, p_rst = 1'b0, p_mosi = 1'b0;
   logic [15:0] tx = '0, rx = '0;
   logic [2:0]  last_addr = '0;

   always @(negedge clk) begin
      logic [14:0] e;
      logic [2:0]  ech;
      logic [11:0] edat;
      int          bi;
      cyc++;

      if (p_rst) begin
         chk("rst_pins", 32'({ADCCLK, nADCCS, ADCMOSI, result_valid, busy}), 32'(5'b11000));
         chk("rst_result", 32'({result_chan, result}), 32'd0);
      end
      if (restart_cnt != seen_restart) begin
         seen_restart = restart_cnt;
         next_k = 0;
      end
      if (rst) begin
         exp_q.delete();
         next_k  = 0;
         aborted = 1'b1;
      end

      if (phase == 1 && (!nADCCS || !ADCCLK || ADCMOSI || busy || result_valid)) idle_act++;
      if (p_phase == 1 && phase != 1) chk("idle_quiet", 32'(idle_act), 32'd0);

      if (p_cs && !nADCCS) begin
         cur_k = next_k;
         next_k++;
         nf = 0; nr = 0; lo_len = 0; rx = '0; viol = 0; busy_viol = 0;
         aborted = 1'b0;
         if (data_mode == 0) tx = {4'h0, 12'hA5C};
         else                tx = {4'h0, 12'h100 + 12'(last_addr)};
         ADCMISO = tx[15];
         if (cur_k >= 1) begin
            chk("gap_len", 32'(hi_len), 32'(GAP));
            ech  = 3'((cur_k - 1) % NCH);
            edat = (data_mode == 0) ? 12'hA5C : 12'h100 + 12'(ech);
            exp_q.push_back({ech, edat});
         end
      end else if (!p_cs && nADCCS) begin
         if (!aborted) begin
            chk("cs_low_len", 32'(lo_len), 32'(34 * CLK_DIV));
            chk("sclk_rises", 32'(nr), 32'd16);
            chk("mosi_word", 32'(rx), 32'({2'b00, 3'(cur_k % NCH), 11'b0}));
            chk("mosi_stable", 32'(viol), 32'd0);
            chk("busy_in_frame", 32'(busy_viol), 32'd0);
            last_addr = rx[13:11];
         end
         hi_len = 0;
      end

      if (!nADCCS) lo_len++;
      else         hi_len++;

      if (!nADCCS && p_sclk && !ADCCLK) begin
         bi = 15 - nf;
         if (bi >= 0) ADCMISO = tx[bi[3:0]];
         nf++;
      end
      if (!nADCCS && !p_sclk && ADCCLK) begin
         rx = {rx[14:0], ADCMOSI};
         nr++;
         if (nr == 16) rise16_t = cyc;
      end
      if (!nADCCS && !p_cs && ADCCLK && p_sclk && ADCMOSI != p_mosi) viol++;
      if (!nADCCS && !busy) busy_viol++;

      if (result_valid) begin
         chk("strobe_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("result", 32'(result), 32'(e[11:0]));
            chk("result_chan", 32'(result_chan), 32'(e[14:12]));
            chk("strobe_lat", 32'(cyc - rise16_t), 32'd1);
         end
         n_strobes++;
      end

      if (phase == 9 && !done) begin
         chk("queue_empty", 32'(exp_q.size()), 32'd0);
         chk("strobe_total", 32'(n_strobes), 32'd11);
         chk("timeouts", 32'(timeouts), 32'd0);
         done = 1'b1;
      end

      p_cs    = nADCCS;
      p_sclk  = ADCCLK;
      p_rst   = rst;
      p_mosi  = ADCMOSI;
      p_phase = phase;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int cnt;
      // Reset held for 3 clk with scan disabled, then a quiet idle stretch
      tick(3);
      rst = 1'b0;
      phase = 1;
      tick(500);
      phase = 2;

      // Run A: constant data; drop scan_en at SHIFT n=7 of frame 2
      data_mode = 0;
      restart_cnt++;
      scan_en = 1'b1;
      cnt = 0;
      while (!(cur_k == 2 && nf == 8) && cnt < 3000) begin tick(1); cnt++; end
      if (cnt >= 3000) timeouts++;
      scan_en = 1'b0;
      cnt = 0;
      while (busy && cnt < 1000) begin tick(1); cnt++; end
      if (cnt >= 1000) timeouts++;
      tick(20);

      // Run B: channel-tagged data; reset at SHIFT n=10 of frame 7
      data_mode = 1;
      restart_cnt++;
      scan_en = 1'b1;
      cnt = 0;
      while (!(cur_k == 7 && nf == 11) && cnt < 3000) begin tick(1); cnt++; end
      if (cnt >= 3000) timeouts++;
      rst = 1'b1;
      tick(2);
      rst = 1'b0;

      // Run C: scan restarts from frame 0 after reset
      cnt = 0;
      while (n_strobes < 11 && cnt < 3000) begin tick(1); cnt++; end
      if (cnt >= 3000) timeouts++;
      scan_en = 1'b0;
      cnt = 0;
      while (busy && cnt < 1000) begin tick(1); cnt++; end
      if (cnt >= 1000) timeouts++;
      tick(10);

      phase = 9;
      cnt = 0;
      while (!done && cnt < 20) begin tick(1); cnt++; end
      if (!done) $display("FAIL final_checks: done=%0d, expected 1", done);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
